oled_spi_arbiter: RTL
=====================

# oled_spi_arbiter

Shares the single 4-wire SPI link to the SSD1306-class OLED between two byte-stream requesters: a command channel (D/C low) for init and configuration sequences, and a pixel channel (D/C high) for frame-buffer streaming. It sits between the display-control logic and the `io_*` pads and owns the serializer, chip-select framing and D/C sequencing. Multi-byte command sequences are atomic. Pixel traffic is chopped into bounded bursts so commands are never blocked for a whole frame.

## Interface
- `CLK_DIV`, default 1: `clk` cycles per SCLK half-period. Must be ≥1.
- `BURST_MAX`, default 16: maximum pixel bytes per grant before re-arbitration. Must be ≥1.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: command byte offered.
- `cmd_byte` in 8: command byte.
- `cmd_last` in 1: final byte of an atomic command sequence; qualified by `cmd_valid`.
- `cmd_ready` out 1: command byte accepted this cycle when `cmd_valid & cmd_ready`.
- `pix_valid` in 1: pixel byte offered.
- `pix_byte` in 8: pixel byte.
- `pix_ready` out 1: pixel handshake, same rule as the command channel.
- `io_sclk` out 1: SPI clock, idle high.
- `io_sdin` out 1: SPI data, MSB first.
- `io_cs` out 1: chip select, active low.
- `io_dc` out 1: 0 = command, 1 = data.
- `busy` out 1: high in every state except IDLE.

## Operation
- **States:**
  - IDLE: `io_cs`=1, `io_sclk`=1.
  - LOAD: `io_cs`=0; ready is asserted for the granted channel only.
  - SHIFT: 8 bits are shifted out.
  - GAP: `io_cs`=1 for exactly 1 cycle, then IDLE.
- **IDLE arbitration** is registered.
  - `cmd_valid` present: grant CMD.
  - Else `pix_valid` present: grant PIX.
  - Else stay in IDLE.
  - On a grant: go to LOAD, set `io_dc` to the grant, clear `burst_cnt`.
- **LOAD:**
  - Handshake: latch the byte, latch `cmd_last` (CMD grant only), `burst_cnt`++ (PIX grant only), go to SHIFT.
  - No valid under a CMD grant: remain in LOAD with `io_cs` low. The sequence is held atomic until a byte carrying `cmd_last` has been sent.
- **SHIFT**, per bit from MSB:
  - `io_sclk`=0 with `io_sdin`=bit for `CLK_DIV` cycles.
  - Then `io_sclk`=1 for `CLK_DIV` cycles.
  - The display samples on the rising edge.
  - `io_sdin` holds its last value after the byte.
- **After bit 0** (the last half-period):
  - CMD grant, `cmd_last` latched 0: go to LOAD.
  - CMD grant, `cmd_last` latched 1: go to GAP.
  - PIX grant: go to LOAD if `pix_valid` & `burst_cnt` < `BURST_MAX` & !`cmd_valid`. Otherwise go to GAP.
- `io_dc` changes only on the IDLE→LOAD transition, never while `io_cs`=0.
- **Counters:** `burst_cnt` is $clog2(BURST_MAX+1) bits. The divider is $clog2(CLK_DIV) bits, minimum 1, and wraps at `CLK_DIV`-1.
- **Reset** (rst_n=0 at a clock edge, any state, including mid-byte): next cycle is IDLE.
  - `io_cs`=1, `io_sclk`=1, `io_sdin`=0, `io_dc`=1, `busy`=0, `cmd_ready`=0, `pix_ready`=0.
  - Counters are cleared and the grant is cleared.
  - A partial byte is dropped, not resumed.

## Timing
- `cmd_ready`/`pix_ready` are combinational from the state and grant registers. They do not depend on the valid inputs.
- Valid sampled in IDLE at edge N:
  - Edge N+1: LOAD, `io_cs`=0.
  - Handshake at edge N+1.
  - N+2: first `io_sclk` low.
- One byte occupies 16·`CLK_DIV` cycles in SHIFT.
- Back-to-back bytes in one grant: 1 LOAD cycle between bytes. The `io_sclk` high level is then extended by 1 cycle; `io_cs` stays low.
- Grant turnaround is GAP (1) + IDLE (1) + LOAD (1) cycles. The minimum CS-high time is 2 cycles.
- Both channels valid simultaneously in IDLE: CMD wins (strict priority, unless `OLED_ARB_FAIR_EN` is defined).

## Configuration
- `OLED_ARB_FAIR_EN` undefined: strict command priority, as above.
- `OLED_ARB_FAIR_EN` defined:
  - A 1-bit `last_grant` register is added, reset to PIX.
  - When both channels are valid in IDLE, the channel not granted last wins.
  - Single-requester behaviour is unchanged.
  - Command atomicity and `BURST_MAX` still apply.

## Structure
- Shared package `oled_pkg`:
  - State enum (IDLE, LOAD, SHIFT, GAP).
  - Grant encoding (`GRANT_CMD`=0, `GRANT_PIX`=1, matching D/C).
  - SSD1306 opcode constants reused by the init sequencers.
- One sub-module, `oled_spi_shift`:
  - Inputs: `start`, `byte`.
  - Outputs: `io_sclk`, `io_sdin`, and a `done` pulse in the final cycle.
  - Parameterized by `CLK_DIV`.
  - The arbiter FSM drives it from LOAD and advances on `done`.

## Test plan
- **Reset mid-byte:** pulse `rst_n`=0 during SHIFT → next cycle `io_cs`=1, `io_sclk`=1, `io_sdin`=0, `io_dc`=1, `busy`=0. The next grant sends a fresh byte.
- **Atomic command:** `CLK_DIV`=1, send 0x81 then 0x7F with `cmd_last`; `pix_valid` is high throughout.
  - 16 rising edges shift 1000_0001, 0111_1111.
  - `io_dc`=0, `io_cs` low continuously.
  - `pix_ready` never asserts until after GAP.
- **Burst chop:** `BURST_MAX`=4, 10 pixel bytes 0x00..0x09 continuously valid → CS frames of 4, 4 and 2 bytes, `io_dc`=1, each separated by ≥2 CS-high cycles.
- **Preemption:** `cmd_valid` (0xAF, last) rises during pixel byte 2 → burst ends after byte 2, the next frame is 0xAF with `io_dc`=0, then pixels resume.
- **Clock divider:** `CLK_DIV`=3, single byte 0xA5 → each `io_sclk` level lasts 3 cycles, sampled bits are 1,0,1,0,0,1,0,1, SHIFT lasts 48 cycles.
- **Fairness** (`OLED_ARB_FAIR_EN` defined, both channels always valid, single-byte commands) → grants alternate CMD, PIX, CMD, …; undefined → CMD every time.

Source files
------------

// File: rtl/oled_pkg.sv
// oled_pkg: shared types and constants for the OLED SPI link.
//   - arb_state_t : arbiter FSM state encoding
//   - grant_t     : channel grant, encoded to match the D/C pin level
//   - SSD_*       : SSD1306 opcodes reused by the init sequencers
package oled_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_CMD = 1'b0,
    GRANT_PIX = 1'b1
  } grant_t;

  localparam logic [7:0] SSD_MEM_ADDR_MODE    = 8'h20;
  localparam logic [7:0] SSD_SET_CONTRAST     = 8'h81;
  localparam logic [7:0] SSD_CHARGE_PUMP      = 8'h8D;
  localparam logic [7:0] SSD_ENTIRE_ON_RESUME = 8'hA4;
  localparam logic [7:0] SSD_NORMAL_DISPLAY   = 8'hA6;
  localparam logic [7:0] SSD_DISPLAY_OFF      = 8'hAE;
  localparam logic [7:0] SSD_DISPLAY_ON       = 8'hAF;

  // Page-start opcode for page addressing mode (B0h..B7h).
  function automatic logic [7:0] ssd_page_start(input logic [2:0] page);
    return 8'hB0 | {5'b0_0000, page};
  endfunction

endpackage

// File: rtl/oled_spi_arbiter_shift.sv
// oled_spi_shift: SPI byte serializer, MSB first, SCLK idle high.
// Each bit drives SCLK low for CLK_DIV cycles with SDIN valid, then high for
// CLK_DIV cycles; the display samples on the rising edge.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   start            : load tx_byte and begin shifting (ignored bits in flight restart)
//   tx_byte[7:0]     : byte to send
//   io_sclk, io_sdin : SPI clock and data (registered); SDIN holds after the byte
//   done             : high during the final cycle of the byte
module oled_spi_shift
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       io_sclk,
  output logic       io_sdin,
  output logic       done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             active;
  logic [7:0]       shreg;
  logic [2:0]       bit_idx;
  logic [DIV_W-1:0] div_cnt;
  logic             half_end;

  assign half_end = (div_cnt == DIV_LAST);
  assign done     = active & io_sclk & half_end & (bit_idx == 3'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active  <= 1'b0;
      shreg   <= 8'h00;
      bit_idx <= 3'd0;
      div_cnt <= '0;
      io_sclk <= 1'b1;
      io_sdin <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      shreg   <= tx_byte;
      bit_idx <= 3'd7;
      div_cnt <= '0;
      io_sclk <= 1'b0;
      io_sdin <= tx_byte[7];
    end else if (active) begin
      if (half_end) begin
        div_cnt <= '0;
        if (!io_sclk) begin
          io_sclk <= 1'b1;
        end else if (bit_idx == 3'd0) begin
          // Leave SCLK high and SDIN on the last bit until the next start.
          active <= 1'b0;
        end else begin
          bit_idx <= bit_idx - 3'd1;
          io_sclk <= 1'b0;
          io_sdin <= shreg[bit_idx - 3'd1];
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/oled_spi_arbiter.sv
// oled_spi_arbiter: shares one 4-wire SPI link to an SSD1306-class OLED
// between a command channel (D/C=0) and a pixel channel (D/C=1).
// Command sequences are atomic up to the byte flagged cmd_last; pixel
// traffic is chopped into bursts of at most BURST_MAX bytes.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   cmd_valid/cmd_byte/cmd_last     : command byte stream
//   cmd_ready                       : command handshake
//   pix_valid/pix_byte, pix_ready   : pixel byte stream and handshake
//   io_sclk, io_sdin, io_cs, io_dc  : SPI pads (CS active low)
//   busy                            : high whenever the FSM is not IDLE
// Build option: define OLED_ARB_FAIR_EN to alternate grants when both
// channels request at once (default: strict command priority).
//
// state | meaning
// IDLE  | CS high, arbitrate between channels
// LOAD  | CS low, ready to granted channel, wait for a byte
// SHIFT | serializer sending the latched byte
// GAP   | CS high for one cycle closing the frame
module oled_spi_arbiter
  import oled_pkg::*;
#(
  parameter int CLK_DIV   = 1,
  parameter int BURST_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_last,
  output logic       cmd_ready,
  input  logic       pix_valid,
  input  logic [7:0] pix_byte,
  output logic       pix_ready,
  output logic       io_sclk,
  output logic       io_sdin,
  output logic       io_cs,
  output logic       io_dc,
  output logic       busy
);

  localparam int BC_W = $clog2(BURST_MAX + 1);
  localparam logic [BC_W-1:0] BURST_LIM = BC_W'(BURST_MAX);

  arb_state_t      state;
  grant_t          grant;
  grant_t          arb_pick;
  logic            last_lat;
  logic [BC_W-1:0] burst_cnt;
  logic            cmd_hs;
  logic            pix_hs;
  logic            shift_start;
  logic            shift_done;
  logic [7:0]      shift_byte;

  assign cmd_ready   = (state == ST_LOAD) && (grant == GRANT_CMD);
  assign pix_ready   = (state == ST_LOAD) && (grant == GRANT_PIX);
  assign busy        = (state != ST_IDLE);
  assign cmd_hs      = cmd_valid & cmd_ready;
  assign pix_hs      = pix_valid & pix_ready;
  assign shift_start = cmd_hs | pix_hs;
  assign shift_byte  = (grant == GRANT_CMD) ? cmd_byte : pix_byte;

`ifdef OLED_ARB_FAIR_EN
  grant_t last_grant;

  always_comb begin
    arb_pick = GRANT_PIX;
    if (cmd_valid && pix_valid)
      arb_pick = (last_grant == GRANT_CMD) ? GRANT_PIX : GRANT_CMD;
    else if (cmd_valid)
      arb_pick = GRANT_CMD;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      last_grant <= GRANT_PIX;
    else if ((state == ST_IDLE) && (cmd_valid || pix_valid))
      last_grant <= arb_pick;
  end
`else
  assign arb_pick = cmd_valid ? GRANT_CMD : GRANT_PIX;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant     <= GRANT_CMD;
      last_lat  <= 1'b0;
      burst_cnt <= '0;
      io_cs     <= 1'b1;
      io_dc     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid || pix_valid) begin
            state     <= ST_LOAD;
            grant     <= arb_pick;
            io_dc     <= arb_pick;
            io_cs     <= 1'b0;
            burst_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (cmd_hs) begin
            last_lat <= cmd_last;
            state    <= ST_SHIFT;
          end else if (pix_hs) begin
            burst_cnt <= burst_cnt + 1'b1;
            state     <= ST_SHIFT;
          end else if (grant == GRANT_PIX) begin
            // Pixel source dropped valid: release the link. A command
            // grant instead holds CS low until its sequence completes.
            state <= ST_GAP;
            io_cs <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (shift_done) begin
            if (grant == GRANT_CMD) begin
              if (last_lat) begin
                state <= ST_GAP;
                io_cs <= 1'b1;
              end else begin
                state <= ST_LOAD;
              end
            end else if (pix_valid && (burst_cnt < BURST_LIM) && !cmd_valid) begin
              state <= ST_LOAD;
            end else begin
              state <= ST_GAP;
              io_cs <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          io_cs <= 1'b1;
        end
      endcase
    end
  end

  oled_spi_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (shift_start),
    .tx_byte (shift_byte),
    .io_sclk (io_sclk),
    .io_sdin (io_sdin),
    .done    (shift_done)
  );

endmodule
